sipo_deserializer: RTL and testbench

Serial-to-parallel receiver that sits at the far end of the universal shift register's serial output. It samples one bit per `sin_valid` strobe and assembles `WIDTH`-bit words, MSB-first or LSB-first. Each completed word is presented on a registered parallel bus with a one-cycle valid pulse. Framing is realigned by a start-of-frame strobe, and a partial word cut short by a new frame is flagged.

---
 rtl/sipo_deserializer.sv | 93 +++++++++
 tb/tb_sipo_deserializer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Purpose: serial-to-parallel receiver assembling WIDTH-bit words, MSB- or LSB-first, with sof realignment.
// Latency: out/out_valid update on the edge that samples the WIDTH-th bit (visible the next cycle).
// Backpressure: none; out_valid pulses for one cycle and out holds until the next word completes.
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  input  logic             sof,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] out_n;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt, cnt_n, cnt_eff;
  logic             dir_q, dir_n;
  logic             d_eff;
  logic             out_valid_n, busy_n, frame_err_n;

  // Next-state: sof realigns first, then the bit (if any) is shifted with the effective direction.
  always_comb begin
    cnt_n       = cnt;
    sh_n        = sh;
    out_n       = out;
    dir_n       = dir_q;
    out_valid_n = 1'b0;
    frame_err_n = 1'b0;
    busy_n      = 1'b0;
    cnt_eff     = cnt;
    d_eff       = dir_q;
    shifted     = sh;

    // A start-of-frame drops whatever partial word was in progress.
    if (sof) begin
      cnt_eff     = '0;
      frame_err_n = (cnt != '0);
    end

    // Direction is re-latched only on the first bit of a word.
    d_eff   = (cnt_eff == '0) ? dir : dir_q;
    shifted = d_eff ? {sin, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], sin};
    cnt_n   = cnt_eff;

    if (sin_valid) begin
      if (cnt_eff == '0) begin
        dir_n = dir;
      end
      if (cnt_eff == LAST) begin
        // Completed word goes straight to the output; sh is overwritten by the next word anyway.
        out_n       = shifted;
        out_valid_n = 1'b1;
        cnt_n       = '0;
      end else begin
        sh_n  = shifted;
        cnt_n = cnt_eff + CW'(1);
      end
    end

    busy_n = (cnt_n != '0);
  end

  // State and registered outputs; clr overrides every other input.
  always_ff @(posedge clk) begin
    if (clr) begin
      sh        <= '0;
      out       <= '0;
      cnt       <= '0;
      dir_q     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sh        <= sh_n;
      out       <= out_n;
      cnt       <= cnt_n;
      dir_q     <= dir_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
      frame_err <= frame_err_n;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr, sin, sin_valid, dir, sof;
  logic [W-1:0] out;
  logic         out_valid, busy, frame_err;

  int total_cnt = 0;
  int pass_cnt  = 0;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .sin       (sin),
    .sin_valid (sin_valid),
    .dir       (dir),
    .sof       (sof),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         c, s, v, d, f;
    logic [W-1:0] e_out;
    logic         e_ov, e_busy, e_fe;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  logic         sb_en = 1'b0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
  endtask

  task automatic add(input logic c, input logic s, input logic v, input logic d, input logic f,
                     input logic [W-1:0] eo, input logic eov, input logic eb, input logic efe);
    vec_t t;
    t.c = c; t.s = s; t.v = v; t.d = d; t.f = f;
    t.e_out = eo; t.e_ov = eov; t.e_busy = eb; t.e_fe = efe;
    vecs.push_back(t);
  endtask

  // Drive one cycle's inputs, let the edge happen, then sample 1 time unit later.
  task automatic apply(input logic c, input logic s, input logic v, input logic d, input logic f);
    clr = c; sin = s; sin_valid = v; dir = d; sof = f;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every out_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (sb_en && out_valid) begin
      if (exp_q.size() == 0) chk("sb_unexpected_word", 0, {28'd0, out}, 32'hdead);
      else chk("sb_word", exp_q.size(), {28'd0, out}, {28'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int           nb;
    logic [W-1:0] word;
    logic         wdir;
    logic         s, v, d, f;
    logic         efe;

    clr = 1'b1; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0; sof = 1'b0;

    // Reset for two cycles (sin_valid asserted on the second to show clr wins).
    add(1,0,0,0,0, 4'b0000,0,0,0);
    add(1,1,1,0,1, 4'b0000,0,0,0);
    // MSB-first 1,0,1,1.
    add(0,1,1,0,0, 4'b0000,0,1,0);
    add(0,0,1,0,0, 4'b0000,0,1,0);
    add(0,1,1,0,0, 4'b0000,0,1,0);
    add(0,1,1,0,0, 4'b1011,1,0,0);
    add(0,0,0,0,0, 4'b1011,0,0,0);
    // LSB-first 1,1,(gap 2),0,1 with dir dropped to 0 after bit 1.
    add(0,1,1,1,0, 4'b1011,0,1,0);
    add(0,1,1,0,0, 4'b1011,0,1,0);
    add(0,1,0,0,0, 4'b1011,0,1,0);
    add(0,0,0,0,0, 4'b1011,0,1,0);
    add(0,0,1,0,0, 4'b1011,0,1,0);
    add(0,1,1,0,0, 4'b1011,1,0,0);
    // Back-to-back 1011 0110.
    add(0,1,1,0,0, 4'b1011,0,1,0);
    add(0,0,1,0,0, 4'b1011,0,1,0);
    add(0,1,1,0,0, 4'b1011,0,1,0);
    add(0,1,1,0,0, 4'b1011,1,0,0);
    add(0,0,1,0,0, 4'b1011,0,1,0);
    add(0,1,1,0,0, 4'b1011,0,1,0);
    add(0,1,1,0,0, 4'b1011,0,1,0);
    add(0,0,1,0,0, 4'b0110,1,0,0);
    // Framing: 1,1 then sof with 0, then 1,0,1 -> 0101.
    add(0,1,1,0,0, 4'b0110,0,1,0);
    add(0,1,1,0,0, 4'b0110,0,1,0);
    add(0,0,1,0,1, 4'b0110,0,1,1);
    add(0,1,1,0,0, 4'b0110,0,1,0);
    add(0,0,1,0,0, 4'b0110,0,1,0);
    add(0,1,1,0,0, 4'b0101,1,0,0);
    // sof while idle at a word boundary: no error.
    add(0,0,0,0,1, 4'b0101,0,0,0);
    // sof together with the last bit: no word, error, bit starts a new word -> 1001.
    add(0,1,1,0,0, 4'b0101,0,1,0);
    add(0,0,1,0,0, 4'b0101,0,1,0);
    add(0,1,1,0,0, 4'b0101,0,1,0);
    add(0,1,1,0,1, 4'b0101,0,1,1);
    add(0,0,1,0,0, 4'b0101,0,1,0);
    add(0,0,1,0,0, 4'b0101,0,1,0);
    add(0,1,1,0,0, 4'b1001,1,0,0);
    // sof without sin_valid mid-word, then 1,1,1,0.
    add(0,1,1,0,0, 4'b1001,0,1,0);
    add(0,0,1,0,0, 4'b1001,0,1,0);
    add(0,0,0,0,1, 4'b1001,0,0,1);
    add(0,1,1,0,0, 4'b1001,0,1,0);
    add(0,1,1,0,0, 4'b1001,0,1,0);
    add(0,1,1,0,0, 4'b1001,0,1,0);
    add(0,0,1,0,0, 4'b1110,1,0,0);
    // Mid-word reset, then 0,0,1,1 -> 0011 with nothing stale.
    add(0,1,1,0,0, 4'b1110,0,1,0);
    add(0,0,1,0,0, 4'b1110,0,1,0);
    add(1,1,1,0,1, 4'b0000,0,0,0);
    add(0,0,1,0,0, 4'b0000,0,1,0);
    add(0,0,1,0,0, 4'b0000,0,1,0);
    add(0,1,1,0,0, 4'b0000,0,1,0);
    add(0,1,1,0,0, 4'b0011,1,0,0);

    @(negedge clk);
    foreach (vecs[i]) begin
      apply(vecs[i].c, vecs[i].s, vecs[i].v, vecs[i].d, vecs[i].f);
      chk("out",       i, {28'd0, out},       {28'd0, vecs[i].e_out});
      chk("out_valid", i, {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk("busy",      i, {31'd0, busy},      {31'd0, vecs[i].e_busy});
      chk("frame_err", i, {31'd0, frame_err}, {31'd0, vecs[i].e_fe});
    end

    // Random stream against a bit-placement model; words go through the scoreboard queue.
    apply(1,0,0,0,0);
    nb = 0; word = '0; wdir = 1'b0;
    sb_en = 1'b1;
    for (int k = 0; k < 400; k++) begin
      s = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 15) == 0);
      efe = f && (nb != 0);
      if (f) nb = 0;
      if (v) begin
        if (nb == 0) wdir = d;
        if (wdir) word[nb] = s;
        else      word[W-1-nb] = s;
        nb++;
        if (nb == W) begin
          exp_q.push_back(word);
          nb = 0;
        end
      end
      apply(0, s, v, d, f);
      chk("rnd_frame_err", k, {31'd0, frame_err}, {31'd0, efe});
      chk("rnd_busy",      k, {31'd0, busy},      {31'd0, 1'(nb != 0)});
    end
    apply(0,0,0,0,0);
    @(negedge clk);
    sb_en = 1'b0;
    chk("sb_leftover", 0, exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
